// File: rtl/gt_video_tx_sched.sv
// GT video transmit scheduler: frames a line-buffered video stream into
// frame-sync / line-sync / payload / idle words, one word per tx_clk.
module gt_video_tx_sched #(
  parameter int unsigned FRAME_GAP = 24,
  parameter int unsigned LINE_GAP  = 2
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic [15:0] vout_width,
  input  logic [15:0] lines_per_frame,
  input  logic [13:0] line_level,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rd_data,
  output logic [31:0] gt_tx_data,
  output logic [3:0]  gt_tx_ctrl,
  output logic        frame_done,
  output logic        err_short_frame
);

  localparam logic [31:0] IDLE_WORD  = 32'h0000_00bc;
  localparam logic [31:0] FSYNC_WORD = 32'hff00_00bc;
  localparam logic [31:0] LSYNC_WORD = 32'hff00_02bc;
  localparam logic [3:0]  K_CTRL     = 4'b0001;
  localparam logic [15:0] FG_LAST    = (FRAME_GAP == 0) ? 16'd0 : 16'(FRAME_GAP - 1);
  localparam logic [15:0] LG_LAST    = (LINE_GAP == 0) ? 16'd0 : 16'(LINE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, FSYNC, FGAP, WAIT_LINE, LSYNC, PAYLOAD, LGAP
  } state_t;

  state_t      state, state_n;
  logic        frame_pend;
  logic [15:0] line_cnt;
  logic [14:0] w_lat;
  logic [15:0] l_lat;
  logic [15:0] gap_cnt;
  logic [14:0] word_cnt;

  state_t      wl_next;
  logic        wl_abort;
  logic        eval_wait;
  logic        abort;
  logic        pay_last;
  logic [31:0] data_n;
  logic [3:0]  ctrl_n;

  // Pixel LSB does not affect the word count (two pixels per word).
  logic unused_bits;
  assign unused_bits = vout_width[0];

  // WAIT_LINE decision; also evaluated on the last gap word so the gap
  // leads straight into the next sync word with no extra idle.
  always_comb begin
    wl_next  = WAIT_LINE;
    wl_abort = 1'b0;
    if (frame_pend) begin
      wl_next  = FSYNC;
      wl_abort = (line_cnt < l_lat);
    end else if (w_lat == '0 || l_lat == '0) begin
      wl_next = IDLE;
    end else if (line_cnt == l_lat) begin
      wl_next = IDLE;
    end else if ({1'b0, line_level} >= w_lat) begin
      wl_next = LSYNC;
    end
  end

  // Next state, FIFO read strobe and next output word.
  always_comb begin
    state_n    = state;
    eval_wait  = 1'b0;
    fifo_rd_en = 1'b0;
    pay_last   = 1'b0;
    abort      = 1'b0;
    data_n     = IDLE_WORD;
    ctrl_n     = K_CTRL;
    case (state)
      IDLE: if (frame_pend) state_n = FSYNC;
      FSYNC: begin
        data_n  = FSYNC_WORD;
        state_n = (FRAME_GAP == 0) ? WAIT_LINE : FGAP;
      end
      FGAP:      if (gap_cnt == FG_LAST) eval_wait = 1'b1;
      WAIT_LINE: eval_wait = 1'b1;
      LSYNC: begin
        data_n     = LSYNC_WORD;
        fifo_rd_en = 1'b1;
        state_n    = PAYLOAD;
      end
      PAYLOAD: begin
        data_n     = fifo_rd_data;
        ctrl_n     = 4'b0000;
        pay_last   = (word_cnt == w_lat - 15'd1);
        fifo_rd_en = !pay_last;
        if (pay_last) state_n = (LINE_GAP == 0) ? WAIT_LINE : LGAP;
      end
      LGAP:      if (gap_cnt == LG_LAST) eval_wait = 1'b1;
      default:   state_n = IDLE;
    endcase
    if (eval_wait) begin
      state_n = wl_next;
      abort   = wl_abort;
    end
  end

  // State, counters, frame parameters and registered GT outputs.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state           <= IDLE;
      frame_pend      <= 1'b0;
      line_cnt        <= '0;
      w_lat           <= '0;
      l_lat           <= '0;
      gap_cnt         <= '0;
      word_cnt        <= '0;
      gt_tx_data      <= IDLE_WORD;
      gt_tx_ctrl      <= K_CTRL;
      frame_done      <= 1'b0;
      err_short_frame <= 1'b0;
    end else begin
      state      <= state_n;
      frame_pend <= vs_in | (frame_pend & (state_n != FSYNC));
      if (state == FSYNC) begin
        w_lat    <= vout_width[15:1];
        l_lat    <= lines_per_frame;
        line_cnt <= '0;
      end else if (pay_last) begin
        line_cnt <= line_cnt + 16'd1;
      end
      gap_cnt         <= ((state == FGAP || state == LGAP) && state_n == state) ? gap_cnt + 16'd1 : '0;
      word_cnt        <= (state == PAYLOAD) ? word_cnt + 15'd1 : '0;
      gt_tx_data      <= data_n;
      gt_tx_ctrl      <= ctrl_n;
      frame_done      <= pay_last && (line_cnt + 16'd1 == l_lat);
      err_short_frame <= abort;
    end
  end

endmodule

// File: tb/tb_gt_video_tx_sched.sv
// Directed bench for gt_video_tx_sched with a counting FIFO model.
module tb_gt_video_tx_sched;

  localparam logic [31:0] IDLE_W  = 32'h0000_00bc;
  localparam logic [31:0] FSYNC_W = 32'hff00_00bc;
  localparam logic [31:0] LSYNC_W = 32'hff00_02bc;
  localparam logic [31:0] BASE    = 32'ha500_0000;

  logic        tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in = 1'b0;
  logic [15:0] vout_width = 16'd8;
  logic [15:0] lines_per_frame = 16'd2;
  logic [13:0] line_level = 14'd16;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic [31:0] gt_tx_data;
  logic [3:0]  gt_tx_ctrl;
  logic        frame_done;
  logic        err_short_frame;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned rd_ptr = 0;
  int unsigned rd_cycles = 0;
  int unsigned err_pulses = 0;
  int unsigned exp_idx = 0;

  always #5 tx_clk = ~tx_clk;

  gt_video_tx_sched #(.FRAME_GAP(24), .LINE_GAP(2)) dut (
    .tx_clk(tx_clk), .rst(rst), .vs_in(vs_in), .vout_width(vout_width),
    .lines_per_frame(lines_per_frame), .line_level(line_level),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .gt_tx_data(gt_tx_data), .gt_tx_ctrl(gt_tx_ctrl),
    .frame_done(frame_done), .err_short_frame(err_short_frame)
  );

  // Upstream FIFO: data one cycle after the read strobe, counting pattern.
  always @(posedge tx_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= BASE + rd_ptr;
      rd_ptr       <= rd_ptr + 1;
      rd_cycles    <= rd_cycles + 1;
    end
    if (err_short_frame) err_pulses <= err_pulses + 1;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge tx_clk);
  endtask

  task automatic pulse_vs();
    vs_in = 1'b1;
    step();
    vs_in = 1'b0;
  endtask

  task automatic wait_word(input string tag, input logic [31:0] w, input int unsigned max);
    bit found = 0;
    for (int unsigned i = 0; i < max; i++) begin
      if (gt_tx_data == w && gt_tx_ctrl == 4'b0001) begin
        found = 1;
        break;
      end
      step();
    end
    chk(tag, 40'(found), 40'd1);
  endtask

  task automatic expect_k(input string tag, input logic [31:0] w, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      chk(tag, {4'h0, gt_tx_ctrl, gt_tx_data}, {8'h01, w});
      step();
    end
  endtask

  task automatic expect_payload(input string tag, input int unsigned n, input bit last_line);
    for (int unsigned k = 0; k < n; k++) begin
      chk(tag, {4'h0, gt_tx_ctrl, gt_tx_data}, {8'h00, BASE + exp_idx});
      chk({tag, "_done"}, 40'(frame_done), 40'(last_line && k == n - 1));
      exp_idx++;
      step();
    end
  endtask

  task automatic expect_quiet(input string tag, input int unsigned n);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (gt_tx_data !== IDLE_W || gt_tx_ctrl !== 4'b0001 || fifo_rd_en !== 1'b0) bad++;
      step();
    end
    chk(tag, 40'(bad), 40'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rd0, err0;
    step();
    step();
    // Reset state
    chk("rst_data", 40'(gt_tx_data), 40'(IDLE_W));
    chk("rst_ctrl", 40'(gt_tx_ctrl), 40'h1);
    chk("rst_rd_en", 40'(fifo_rd_en), 40'h0);
    chk("rst_done", 40'(frame_done), 40'h0);
    chk("rst_err", 40'(err_short_frame), 40'h0);
    rst = 1'b0;
    expect_quiet("no_vs_quiet", 100);

    // Two-line frame, W=4
    exp_idx = rd_ptr;
    rd0 = rd_cycles;
    pulse_vs();
    wait_word("f1_fsync_seen", FSYNC_W, 10);
    expect_k("f1_fsync", FSYNC_W, 1);
    expect_k("f1_fgap", IDLE_W, 24);
    expect_k("f1_lsync0", LSYNC_W, 1);
    expect_payload("f1_pay0", 4, 1'b0);
    expect_k("f1_lgap", IDLE_W, 2);
    expect_k("f1_lsync1", LSYNC_W, 1);
    expect_payload("f1_pay1", 4, 1'b1);
    expect_quiet("f1_tail", 20);
    chk("f1_rd_count", 40'(rd_cycles - rd0), 40'd8);

    // Line waits for FIFO level to reach W
    lines_per_frame = 16'd1;
    line_level = 14'd3;
    exp_idx = rd_ptr;
    pulse_vs();
    wait_word("lvl_fsync_seen", FSYNC_W, 10);
    step();
    expect_quiet("lvl_wait", 40);
    line_level = 14'd4;
    step();
    chk("lvl_rd_en", 40'(fifo_rd_en), 40'h1);
    chk("lvl_pre_data", 40'(gt_tx_data), 40'(IDLE_W));
    step();
    expect_k("lvl_lsync", LSYNC_W, 1);
    expect_payload("lvl_pay", 4, 1'b1);
    line_level = 14'd16;
    expect_quiet("lvl_tail", 20);

    // Early vs_in during line 1 of 4
    lines_per_frame = 16'd4;
    exp_idx = rd_ptr;
    err0 = err_pulses;
    pulse_vs();
    wait_word("ab_fsync_seen", FSYNC_W, 10);
    expect_k("ab_fsync", FSYNC_W, 1);
    expect_k("ab_fgap", IDLE_W, 24);
    expect_k("ab_lsync0", LSYNC_W, 1);
    expect_payload("ab_pay0", 4, 1'b0);
    expect_k("ab_lgap0", IDLE_W, 2);
    chk("ab_lsync1", {4'h0, gt_tx_ctrl, gt_tx_data}, {8'h01, LSYNC_W});
    pulse_vs();
    expect_payload("ab_pay1", 4, 1'b0);
    expect_k("ab_lgap1", IDLE_W, 2);
    expect_k("ab_refsync", FSYNC_W, 1);
    chk("ab_err_once", 40'(err_pulses - err0), 40'd1);
    expect_k("ab_fgap2", IDLE_W, 24);
    for (int unsigned ln = 0; ln < 4; ln++) begin
      expect_k("ab_new_lsync", LSYNC_W, 1);
      expect_payload("ab_new_pay", 4, ln == 3);
      if (ln != 3) expect_k("ab_new_lgap", IDLE_W, 2);
    end
    expect_quiet("ab_tail", 10);
    chk("ab_err_total", 40'(err_pulses - err0), 40'd1);

    // Reset on the second payload word
    lines_per_frame = 16'd2;
    exp_idx = rd_ptr;
    pulse_vs();
    wait_word("rs_lsync_seen", LSYNC_W, 40);
    step();
    expect_payload("rs_pay0", 1, 1'b0);
    chk("rs_pay1", {4'h0, gt_tx_ctrl, gt_tx_data}, {8'h00, BASE + exp_idx});
    rst = 1'b1;
    step();
    chk("rs_idle_word", {4'h0, gt_tx_ctrl, gt_tx_data}, {8'h01, IDLE_W});
    chk("rs_rd_en", 40'(fifo_rd_en), 40'h0);
    rst = 1'b0;
    expect_quiet("rs_after", 80);

    // Width 1 -> W=0, frame disabled
    vout_width = 16'd1;
    rd0 = rd_cycles;
    pulse_vs();
    wait_word("w0_fsync_seen", FSYNC_W, 10);
    expect_k("w0_fsync", FSYNC_W, 1);
    expect_k("w0_fgap", IDLE_W, 24);
    expect_quiet("w0_after", 40);
    chk("w0_rd_count", 40'(rd_cycles - rd0), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
